// File: rtl/mmio_io_controller.sv
// Data-memory bus responder that owns the button, status and output-port MMIO addresses.
// Optional saturating press counter at BUTTON_ADDR+8 is enabled by defining MMIO_PRESS_COUNT_EN.
module mmio_io_controller #(
  parameter logic [31:0] BUTTON_ADDR     = 32'd1000,
  parameter logic [31:0] STATUS_ADDR     = 32'd1004,
  parameter logic [31:0] OUTPUT_ADDR     = 32'd2000,
  parameter int          FIFO_DEPTH      = 8,
  parameter int          DEBOUNCE_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  input  logic [31:0] ram_q,
  output logic [31:0] q_dmem,
  input  logic        button_in,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic {STABLE, COUNTING} db_state_e;

  logic          sync1_q, sync1_d, sync2_q, sync2_d;
  db_state_e     state_q, state_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d, db_cnt_inc;
  logic          btn_level_q, btn_level_d;
  logic          press_flag_q, press_flag_d;
  logic          overflow_q, overflow_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic sel_btn, sel_status, sel_out;
  logic press_event, fifo_valid, fifo_full, push, pop, push_ok;

  assign sel_btn    = (address_dmem == BUTTON_ADDR);
  assign sel_status = (address_dmem == STATUS_ADDR);
  assign sel_out    = (address_dmem == OUTPUT_ADDR);

  // Debounce: a new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    sync1_d     = button_in;
    sync2_d     = sync1_q;
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    btn_level_d = btn_level_q;
    db_cnt_inc  = db_cnt_q + DW'(1);
    case (state_q)
      STABLE: begin
        if (sync2_q != btn_level_q) begin
          state_d  = COUNTING;
          db_cnt_d = DW'(1);
        end
      end
      COUNTING: begin
        if (sync2_q == btn_level_q) begin
          state_d  = STABLE;
          db_cnt_d = '0;
        end else if (db_cnt_inc == DW'(DEBOUNCE_CYCLES)) begin
          btn_level_d = sync2_q;
          state_d     = STABLE;
          db_cnt_d    = '0;
        end else begin
          db_cnt_d = db_cnt_inc;
        end
      end
      default: begin
        state_d  = STABLE;
        db_cnt_d = '0;
      end
    endcase
  end

  assign press_event = btn_level_d & ~btn_level_q;

  always_comb begin
    press_flag_d = press_flag_q;
    if (press_event) begin
      press_flag_d = 1'b1;
    end else if (wren && sel_btn) begin
      press_flag_d = 1'b0;
    end
  end

  assign fifo_valid = (count_q != '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign push       = wren && sel_out;
  assign pop        = fifo_valid && out_ready;
  assign push_ok    = push && (!fifo_full || pop);

  // A push that finds the FIFO full with no pop to make room is dropped and flagged.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && !push_ok) begin
      overflow_d = 1'b1;
    end else if (wren && sel_status) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= STABLE;
      db_cnt_q     <= '0;
      btn_level_q  <= 1'b0;
      press_flag_q <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      state_q      <= state_d;
      db_cnt_q     <= db_cnt_d;
      btn_level_q  <= btn_level_d;
      press_flag_q <= press_flag_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

`ifdef MMIO_PRESS_COUNT_EN
  logic        sel_pcnt, pcnt_clear;
  logic [15:0] press_cnt_q, press_cnt_d;

  assign sel_pcnt   = (address_dmem == BUTTON_ADDR + 32'd8);
  assign pcnt_clear = wren && sel_pcnt;

  // An increment coinciding with a clear leaves exactly that one press counted.
  always_comb begin
    press_cnt_d = press_cnt_q;
    if (press_event) begin
      if (pcnt_clear) begin
        press_cnt_d = 16'd1;
      end else if (press_cnt_q != 16'hFFFF) begin
        press_cnt_d = press_cnt_q + 16'd1;
      end
    end else if (pcnt_clear) begin
      press_cnt_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      press_cnt_q <= '0;
    end else begin
      press_cnt_q <= press_cnt_d;
    end
  end
`endif

  assign out_valid = reset && fifo_valid;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // While reset is held, I/O addresses read as zero rather than exposing stale state.
  always_comb begin
    q_dmem = ram_q;
    if (sel_btn) begin
      q_dmem = reset ? {30'b0, press_flag_q, btn_level_q} : '0;
    end else if (sel_status) begin
      q_dmem = reset ? {overflow_q, 15'b0, 16'(count_q)} : '0;
    end else if (sel_out) begin
      q_dmem = '0;
    end
`ifdef MMIO_PRESS_COUNT_EN
    else if (sel_pcnt) begin
      q_dmem = reset ? {16'b0, press_cnt_q} : '0;
    end
`endif
  end

endmodule

// File: tb/tb_mmio_io_controller.sv
// Self-checking bench for mmio_io_controller: every-cycle model comparison plus directed literal checks.
module tb_mmio_io_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] address_dmem = 32'd500;
  logic [31:0] data = 32'd0;
  logic        wren = 1'b0;
  logic [31:0] ram_q = 32'h1234_5678;
  logic [31:0] q_dmem;
  logic        button_in = 1'b1;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  localparam int DEB = 4;
  localparam int DEPTH = 8;

  mmio_io_controller dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .ram_q        (ram_q),
    .q_dmem       (q_dmem),
    .button_in    (button_in),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 clock = ~clock;

  // Behavioural model: raw button history, run length of disagreeing samples, word queue.
  logic        m_sync1 = 1'b0, m_sync2 = 1'b0, m_level = 1'b0, m_press = 1'b0, m_ovf = 1'b0;
  int          m_run = 0;
  logic [31:0] m_fifo[$];
  logic [15:0] m_pcnt = 16'd0;
  logic        s_old, pressed, pop_m, full_m, newovf;

  always @(posedge clock) begin
    if (!reset) begin
      m_sync1 = 1'b0; m_sync2 = 1'b0; m_level = 1'b0; m_press = 1'b0; m_ovf = 1'b0;
      m_run = 0; m_fifo.delete(); m_pcnt = 16'd0;
      check_en = 1'b1;
    end else begin
      s_old = m_sync2;
      pressed = 1'b0;
      if (s_old != m_level) begin
        m_run = m_run + 1;
        if (m_run == DEB) begin
          m_level = s_old;
          m_run = 0;
          pressed = s_old;
        end
      end else begin
        m_run = 0;
      end
      m_sync2 = m_sync1;
      m_sync1 = button_in;
      if (pressed) m_press = 1'b1;
      else if (wren && address_dmem == 32'd1000) m_press = 1'b0;
      full_m = (m_fifo.size() == DEPTH);
      pop_m = (m_fifo.size() != 0) && out_ready;
      newovf = 1'b0;
      if (pop_m) void'(m_fifo.pop_front());
      if (wren && address_dmem == 32'd2000) begin
        if (full_m && !pop_m) newovf = 1'b1;
        else m_fifo.push_back(data);
      end
      if (newovf) m_ovf = 1'b1;
      else if (wren && address_dmem == 32'd1004) m_ovf = 1'b0;
      if (pressed) begin
        if (wren && address_dmem == 32'd1008) m_pcnt = 16'd1;
        else if (m_pcnt != 16'hFFFF) m_pcnt = m_pcnt + 16'd1;
      end else if (wren && address_dmem == 32'd1008) begin
        m_pcnt = 16'd0;
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [15:0] cnt16;
    cnt16 = 16'(m_fifo.size());
    if (a == 32'd1000) return reset ? {30'b0, m_press, m_level} : 32'd0;
    if (a == 32'd1004) return reset ? {m_ovf, 15'b0, cnt16} : 32'd0;
    if (a == 32'd2000) return 32'd0;
`ifdef MMIO_PRESS_COUNT_EN
    if (a == 32'd1008) return reset ? {16'b0, m_pcnt} : 32'd0;
`endif
    return ram_q;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("model_q_dmem", q_dmem, model_read(address_dmem));
      checkOutput("model_out_valid", {31'b0, out_valid}, {31'b0, reset && (m_fifo.size() != 0)});
      checkOutput("model_out_data", out_data,
                  (reset && m_fifo.size() != 0) ? m_fifo[0] : 32'd0);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
    address_dmem = addr;
    data = wdata;
    wren = we;
  endtask

  task automatic writeWord(input logic [31:0] addr, input logic [31:0] wdata);
    applyStimulus(addr, wdata, 1'b1);
    tick();
    wren = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [31:0] addr, input logic [31:0] expected);
    applyStimulus(addr, 32'd0, 1'b0);
    #1;
    checkOutput(name, q_dmem, expected);
  endtask

  task automatic fillFifo(input int base, input int step);
    for (int i = 0; i < DEPTH; i++) writeWord(32'd2000, 32'(base + step * i));
  endtask

  task automatic drainCheck(input string name, input int base, input int step);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput({name, "_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({name, "_data"}, out_data, 32'(base + step * i));
      tick();
    end
    out_ready = 1'b0;
    checkOutput({name, "_empty"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset held for two edges with the button pressed.
    tick(); tick();
    readCheck("rst_status", 32'd1004, 32'd0);
    readCheck("rst_button", 32'd1000, 32'd0);
    checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_data", out_data, 32'd0);
    reset = 1'b1;
    repeat (5) tick();
    readCheck("btn_after5", 32'd1000, 32'd0);
    tick();
    readCheck("btn_after6", 32'd1000, 32'd3);

    // Release the button and clear the press flag.
    button_in = 1'b0;
    repeat (8) tick();
    writeWord(32'd1000, 32'd0);
    readCheck("btn_released", 32'd1000, 32'd0);

    // Bounce rejection.
    for (int i = 0; i < 20; i++) begin
      button_in = ((i / 2) % 2 == 0);
      tick();
      readCheck("bounce_level", 32'd1000, 32'd0);
    end
    button_in = 1'b1;
    repeat (5) tick();
    readCheck("hold_after5", 32'd1000, 32'd0);
    tick();
    readCheck("hold_after6", 32'd1000, 32'd3);
    writeWord(32'd1000, 32'd0);
    readCheck("press_cleared", 32'd1000, 32'd1);

    // FIFO order and fill.
    fillFifo(10, 10);
    readCheck("fill_status", 32'd1004, 32'd8);
    checkOutput("fill_head", out_data, 32'd10);
    drainCheck("drain", 10, 10);

    // Overflow: the ninth word is dropped.
    fillFifo(1, 1);
    writeWord(32'd2000, 32'd99);
    readCheck("ovf_status", 32'd1004, 32'h8000_0008);
    writeWord(32'd1004, 32'd0);
    readCheck("ovf_cleared", 32'd1004, 32'd8);
    drainCheck("ovf_drain", 1, 1);

    // Push and pop together while full.
    fillFifo(1, 1);
    applyStimulus(32'd2000, 32'd9, 1'b1);
    out_ready = 1'b1;
    tick();
    wren = 1'b0;
    out_ready = 1'b0;
    readCheck("pp_status", 32'd1004, 32'd8);
    checkOutput("pp_head", out_data, 32'd2);
    drainCheck("pp_drain", 2, 1);
    readCheck("pp_no_ovf", 32'd1004, 32'd0);

    // Reset in the middle of a drain discards everything.
    button_in = 1'b0;
    for (int i = 0; i < 4; i++) writeWord(32'd2000, 32'(100 + i));
    out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b0;
    checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    readCheck("mid_rst_status", 32'd1004, 32'd0);
    readCheck("mid_rst_button", 32'd1000, 32'd0);

    // RAM passthrough.
    ram_q = 32'hDEAD_BEEF;
    readCheck("passthru", 32'd500, 32'hDEAD_BEEF);
    readCheck("out_addr_read", 32'd2000, 32'd0);

    // Three debounced presses after clearing the counter location.
    writeWord(32'd1008, 32'd0);
    repeat (3) begin
      button_in = 1'b1;
      repeat (8) tick();
      button_in = 1'b0;
      repeat (8) tick();
    end
    ram_q = 32'hCAFE_F00D;
`ifdef MMIO_PRESS_COUNT_EN
    readCheck("press_count", 32'd1008, 32'd3);
    writeWord(32'd1008, 32'd0);
    readCheck("press_count_clr", 32'd1008, 32'd0);
`else
    readCheck("addr1008_ram", 32'd1008, 32'hCAFE_F00D);
`endif
    readCheck("final_button", 32'd1000, 32'd2);

    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
